// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and constants for the data-side memory
// responder.
//   state_t          - responder FSM state (IDLE, SECOND, RESPOND)
//   SECTIONS_*       - memory_write_sections encodings
//   DEFAULT_*        - default RAM size and LED register address
//   section_width()  - access width in bytes for a sections value (0 = illegal)
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SECOND  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [2:0] SECTIONS_READ = 3'b000;
  localparam logic [2:0] SECTIONS_BYTE = 3'b001;
  localparam logic [2:0] SECTIONS_HALF = 3'b011;
  localparam logic [2:0] SECTIONS_WORD = 3'b111;

  localparam int unsigned DEFAULT_DATA_MEMORY_SIZE = 4096;
  localparam logic [31:0] DEFAULT_LED_ADDRESS      = 32'h0001_0000;

  // Reads are always a full word; any sections value outside the table is
  // reported as width 0 so the caller can fault it.
  function automatic logic [2:0] section_width(input logic [2:0] sections);
    logic [2:0] w;
    unique case (sections)
      SECTIONS_READ: w = 3'd4;
      SECTIONS_BYTE: w = 3'd1;
      SECTIONS_HALF: w = 3'd2;
      SECTIONS_WORD: w = 3'd4;
      default:       w = 3'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_memory_bank.sv
// data_memory_bank: word-organised RAM with four byte enables and a
// registered read port (read data appears the cycle after the address).
// The RTL carries no contents of its own; the program image
// target/memory.hex is loaded into this array by the implementation flow.
//   clk_i    - clock, rising edge
//   addr_i   - word index (read and write share the address)
//   we_i     - per-byte write enables, bit i covers wdata_i[8*i +: 8]
//   wdata_i  - write data
//   rdata_o  - registered read data (old contents on a same-cycle write)
module data_memory_bank #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// data_memory: data-side memory responder for the core's load/store port.
// Decodes requests, checks faults, rotates lanes/data by the byte offset,
// splits word-crossing accesses over two RAM cycles and owns the LED register.
// Optional feature macro: DATA_MEMORY_LED_MMIO_EN (LED register mapped at
// LED_ADDRESS; when undefined the address is unmapped and led_on is 0).
//   clk48 / reset           - clock and synchronous active-high reset
//   request_valid/ready     - request handshake; a request is taken on a
//                             cycle where both are high. ready is high only in
//                             IDLE and never during reset; the core holds the
//                             request stable until it is taken.
//   memory_address          - byte address
//   memory_write_sections   - lane selection, 000 = read
//   memory_write_value      - write data, little-endian
//   response_valid          - one-cycle completion pulse, no backpressure
//   response_value          - read data (0 for writes and faults)
//   response_fault          - request was rejected
//   led_on                  - LED register
//   debug_state_o           - current FSM state
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_MEMORY_SIZE = DEFAULT_DATA_MEMORY_SIZE,
  parameter logic [31:0] LED_ADDRESS      = DEFAULT_LED_ADDRESS
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [31:0] memory_address,
  input  logic [2:0]  memory_write_sections,
  input  logic [31:0] memory_write_value,
  output logic        response_valid,
  output logic [31:0] response_value,
  output logic        response_fault,
  output logic        led_on,
  output state_t      debug_state_o
);

  localparam int unsigned WORDS = DATA_MEMORY_SIZE / 4;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t state_q, state_d;

  // ---------------- request decode ----------------
  logic [2:0]  width;
  logic        is_write, accept, is_led, led_overlap, fault, crossing;
  logic [32:0] last_byte;
  logic [1:0]  off;
  logic [3:0]  lane_mask;
  logic [7:0]  lanes8;
  logic [63:0] data64;
  logic [AW-1:0] word_idx;

  assign width     = section_width(memory_write_sections);
  assign is_write  = (memory_write_sections != SECTIONS_READ);
  assign off       = memory_address[1:0];
  assign word_idx  = memory_address[AW+1:2];
  // 33-bit sum so an access running past 0xFFFF_FFFF shows up in bit 32.
  assign last_byte = {1'b0, memory_address} + {30'b0, width} - 33'd1;

`ifdef DATA_MEMORY_LED_MMIO_EN
  assign is_led      = (memory_address == LED_ADDRESS);
  assign led_overlap = !is_led
                     && ({1'b0, memory_address} <= {1'b0, LED_ADDRESS} + 33'd3)
                     && (last_byte >= {1'b0, LED_ADDRESS});
`else
  assign is_led      = 1'b0;
  assign led_overlap = 1'b0;
`endif

  assign fault = (width == 3'd0) || last_byte[32] || led_overlap
              || (!is_led && (last_byte > 33'(DATA_MEMORY_SIZE - 1)));

  assign crossing = (4'(off) + 4'(width)) > 4'd4;

  always_comb begin
    lane_mask = 4'b0000;
    unique case (memory_write_sections)
      SECTIONS_BYTE: lane_mask = 4'b0001;
      SECTIONS_HALF: lane_mask = 4'b0011;
      SECTIONS_WORD: lane_mask = 4'b1111;
      default:       lane_mask = 4'b0000;
    endcase
  end

  // Lanes and data rotated into an 8-byte window: low half goes to the
  // addressed word, high half to the next word on a crossing access.
  assign lanes8 = {4'b0000, lane_mask} << off;
  assign data64 = {32'b0, memory_write_value} << {off, 3'b000};

  assign accept = request_valid && request_ready;

  // ---------------- RAM bank ----------------
  logic [AW-1:0] bank_addr;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata, bank_rdata;

  logic          fault_q, led_acc_q, is_write_q, cross_q;
  logic [1:0]    off_q;
  logic [AW-1:0] upper_idx_q;
  logic [3:0]    upper_lanes_q;
  logic [31:0]   upper_data_q, lo_data_q;

  always_comb begin
    bank_addr  = word_idx;
    bank_we    = 4'b0000;
    bank_wdata = data64[31:0];
    if (state_q == SECOND) begin
      bank_addr  = upper_idx_q;
      bank_wdata = upper_data_q;
      // A reset landing in SECOND drops the upper half of a crossing write.
      if (is_write_q && !reset) bank_we = upper_lanes_q;
    end else if (accept && !fault && !is_led && is_write) begin
      bank_we = lanes8[3:0];
    end
  end

  data_memory_bank #(
    .DEPTH (WORDS),
    .AW    (AW)
  ) u_bank (
    .clk_i   (clk48),
    .addr_i  (bank_addr),
    .we_i    (bank_we),
    .wdata_i (bank_wdata),
    .rdata_o (bank_rdata)
  );

  // ---------------- request context ----------------
  always_ff @(posedge clk48) begin
    if (reset) begin
      fault_q       <= 1'b0;
      led_acc_q     <= 1'b0;
      is_write_q    <= 1'b0;
      cross_q       <= 1'b0;
      off_q         <= 2'd0;
      upper_idx_q   <= '0;
      upper_lanes_q <= 4'b0000;
      upper_data_q  <= 32'b0;
      lo_data_q     <= 32'b0;
    end else begin
      if (accept) begin
        fault_q       <= fault;
        led_acc_q     <= is_led && !fault;
        is_write_q    <= is_write;
        cross_q       <= crossing && !fault && !is_led;
        off_q         <= off;
        upper_idx_q   <= word_idx + AW'(1);
        upper_lanes_q <= lanes8[7:4];
        upper_data_q  <= data64[63:32];
      end
      // Lower word of a crossing read is on the bank output during SECOND.
      if (state_q == SECOND) lo_data_q <= bank_rdata;
    end
  end

  // ---------------- LED register ----------------
`ifdef DATA_MEMORY_LED_MMIO_EN
  logic        led_q;
  logic [31:0] byte_mask;
  assign byte_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                      {8{lane_mask[1]}}, {8{lane_mask[0]}}};

  always_ff @(posedge clk48) begin
    if (reset) begin
      led_q <= 1'b0;
    end else if (accept && is_led && !fault && is_write) begin
      led_q <= (memory_write_value & byte_mask) != 32'b0;
    end
  end
  assign led_on = led_q;
`else
  assign led_on = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk48) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (!fault && !is_led && crossing) ? SECOND : RESPOND;
      SECOND:  state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [63:0] joined;
  assign joined = {bank_rdata, lo_data_q} >> {off_q, 3'b000};

  always_comb begin
    request_ready  = (state_q == IDLE) && !reset;
    response_valid = (state_q == RESPOND);
    response_fault = (state_q == RESPOND) && fault_q;
    response_value = 32'b0;
    if (state_q == RESPOND && !fault_q && !is_write_q) begin
      if (led_acc_q)    response_value = {31'b0, led_on};
      else if (cross_q) response_value = joined[31:0];
      else              response_value = bank_rdata;
    end
  end

  assign debug_state_o = state_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int unsigned SIZE = 4096;
  localparam logic [31:0] LED  = 32'h0001_0000;
`ifdef DATA_MEMORY_LED_MMIO_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic        clk48 = 1'b0;
  logic        reset;
  logic        request_valid;
  logic        request_ready;
  logic [31:0] memory_address;
  logic [2:0]  memory_write_sections;
  logic [31:0] memory_write_value;
  logic        response_valid;
  logic [31:0] response_value;
  logic        response_fault;
  logic        led_on;
  state_t      debug_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mem_m [SIZE];
  logic       led_m = 1'b0;

  data_memory #(.DATA_MEMORY_SIZE(SIZE), .LED_ADDRESS(LED)) dut (
    .clk48                 (clk48),
    .reset                 (reset),
    .request_valid         (request_valid),
    .request_ready         (request_ready),
    .memory_address        (memory_address),
    .memory_write_sections (memory_write_sections),
    .memory_write_value    (memory_write_value),
    .response_valid        (response_valid),
    .response_value        (response_value),
    .response_fault        (response_fault),
    .led_on                (led_on),
    .debug_state_o         (debug_state)
  );

  // ---------------- clock ----------------
  always #5 clk48 = ~clk48;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: applies the access rules byte by byte.
  task automatic model_req(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                           output logic [31:0] ev, output logic ef, output int el);
    int     w;
    longint last;
    bit     led_hit;
    case (s)
      3'b000:  w = 4;
      3'b001:  w = 1;
      3'b011:  w = 2;
      3'b111:  w = 4;
      default: w = 0;
    endcase
    last    = longint'(a) + longint'(w) - 1;
    led_hit = LED_EN && (a == LED);
    ef = (w == 0) || (last > longint'(32'hFFFF_FFFF))
      || (!led_hit && last > longint'(SIZE - 1))
      || (LED_EN && !led_hit && longint'(a) <= longint'(LED) + 3 && last >= longint'(LED));
    ev = 32'b0;
    el = 1;
    if (!ef) begin
      if (led_hit) begin
        if (s != 3'b000) led_m = (wd & ((w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*w)) - 1))) != 0;
        else             ev = {31'b0, led_m};
      end else begin
        if ((a % 4) + w > 4) el = 2;
        for (int i = 0; i < w; i++) begin
          if (s != 3'b000) mem_m[a + i] = wd[8*i +: 8];
          else             ev[8*i +: 8] = mem_m[a + i];
        end
      end
    end
  endtask

  // One request: drive, wait for the response within a bounded window, compare.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] ev;
    logic        ef, gf;
    int          el, lat;
    model_req(a, s, wd, ev, ef, el);
    @(negedge clk48);
    check({tag, ".ready"}, 32'(request_ready), 32'd1);
    request_valid         = 1'b1;
    memory_address        = a;
    memory_write_sections = s;
    memory_write_value    = wd;
    @(posedge clk48);
    #1;
    request_valid         = 1'b0;
    memory_address        = $urandom;
    memory_write_sections = 3'($urandom_range(0, 7));
    memory_write_value    = $urandom;
    lat = 0;
    got = 32'hxxxx_xxxx;
    gf  = 1'bx;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk48);
      if (response_valid) begin
        lat = c;
        got = response_value;
        gf  = response_fault;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(el));
    check({tag, ".fault"}, 32'(gf), 32'(ef));
    check({tag, ".value"}, got, ev);
    check({tag, ".led_on"}, 32'(led_on), 32'(led_m));
    @(negedge clk48);
    check({tag, ".pulse"}, 32'(response_valid), 32'd0);
  endtask

  logic [31:0] got, wd;
  logic [2:0]  sec_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  initial begin
    reset                 = 1'b1;
    request_valid         = 1'b1;
    memory_address        = 32'h10;
    memory_write_sections = 3'b111;
    memory_write_value    = 32'h5555_5555;

    // reset state; a request presented during reset must be ignored
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    check("rst.ready", 32'(request_ready), 32'd0);
    check("rst.valid", 32'(response_valid), 32'd0);
    check("rst.value", response_value, 32'd0);
    check("rst.fault", 32'(response_fault), 32'd0);
    check("rst.led", 32'(led_on), 32'd0);
    check("rst.state", 32'(debug_state), 32'(IDLE));
    request_valid = 1'b0;
    reset         = 1'b0;
    @(negedge clk48);
    check("post_rst.ready", 32'(request_ready), 32'd1);

    // clear the whole RAM so the model starts from known contents
    for (int i = 0; i < SIZE / 4; i++) do_req("fill", 32'(4 * i), 3'b111, 32'h0, got);

    // crossing write over zeroed words
    do_req("cross_wr", 32'h0E, 3'b111, 32'h1122_3344, got);
    do_req("cross_rd_lo", 32'h0C, 3'b000, 32'h0, got);
    check("cross_rd_lo.const", got, 32'h3344_0000);
    do_req("cross_rd_hi", 32'h10, 3'b000, 32'h0, got);
    check("cross_rd_hi.const", got, 32'h0000_1122);
    do_req("cross_rd_mid", 32'h0E, 3'b000, 32'h0, got);
    check("cross_rd_mid.const", got, 32'h1122_3344);

    // aligned word write/read
    do_req("word_wr", 32'h10, 3'b111, 32'hDEAD_BEEF, got);
    do_req("word_rd", 32'h10, 3'b000, 32'h0, got);
    check("word_rd.const", got, 32'hDEAD_BEEF);

    // byte write into a zeroed word
    do_req("byte_wr", 32'h21, 3'b001, 32'h0000_00AA, got);
    do_req("byte_rd", 32'h20, 3'b000, 32'h0, got);
    check("byte_rd.const", got, 32'h0000_AA00);
    do_req("half_wr", 32'h26, 3'b011, 32'hFFFF_1234, got);
    do_req("half_rd", 32'h24, 3'b000, 32'h0, got);
    check("half_rd.const", got, 32'h1234_0000);

    // faults
    do_req("bad_sec", 32'h44, 3'b100, 32'hFFFF_FFFF, got);
    do_req("bad_sec_rd", 32'h44, 3'b000, 32'h0, got);
    check("bad_sec_rd.const", got, 32'h0);
    do_req("top_rd", 32'(SIZE - 2), 3'b000, 32'h0, got);
    do_req("top_byte", 32'(SIZE - 1), 3'b001, 32'h77, got);
    do_req("ovf_rd", 32'hFFFF_FFFE, 3'b000, 32'h0, got);

    // LED register (or unmapped address in the default build)
    do_req("led_wr1", LED, 3'b111, 32'h1, got);
    do_req("led_rd", LED, 3'b000, 32'h0, got);
    do_req("led_wr_hi", LED, 3'b111, 32'h0100_0000, got);
    do_req("led_wr_byte0", LED, 3'b001, 32'hFFFF_FF00, got);
    do_req("led_part", LED + 32'd1, 3'b001, 32'h1, got);
    do_req("led_wr0", LED, 3'b111, 32'h0, got);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [2:0]  s;
      int          cat;
      cat = $urandom_range(0, 9);
      if (cat <= 6)      a = 32'($urandom_range(0, SIZE + 3));
      else if (cat == 7) a = 32'(SIZE - $urandom_range(1, 8));
      else if (cat == 8) a = LED - 32'd3 + 32'($urandom_range(0, 7));
      else               a = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(0, 7));
      else                           s = sec_tab[$urandom_range(0, 3)];
      wd = $urandom;
      do_req("rand", a, s, wd, got);
    end

    // reset while the upper half of a crossing write is pending
    do_req("pre_upper", 32'h40, 3'b111, 32'hCAFE_F00D, got);
    do_req("pre_lower", 32'h3C, 3'b111, 32'h0BAD_0BAD, got);
    wd = $urandom;
    @(negedge clk48);
    request_valid         = 1'b1;
    memory_address        = 32'h3E;
    memory_write_sections = 3'b111;
    memory_write_value    = wd;
    @(posedge clk48);
    #1;
    request_valid = 1'b0;
    @(negedge clk48);
    check("rst2.in_second", 32'(debug_state), 32'(SECOND));
    reset = 1'b1;
    @(negedge clk48);
    check("rst2.valid_in_rst", 32'(response_valid), 32'd0);
    check("rst2.ready_in_rst", 32'(request_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk48);
    check("rst2.valid_after", 32'(response_valid), 32'd0);
    check("rst2.ready_after", 32'(request_ready), 32'd1);
    @(negedge clk48);
    check("rst2.valid_late", 32'(response_valid), 32'd0);
    mem_m[32'h3E] = wd[7:0];
    mem_m[32'h3F] = wd[15:8];
    led_m = 1'b0;
    do_req("rst2_lo", 32'h3C, 3'b000, 32'h0, got);
    check("rst2_lo.const", got, {wd[15:0], 16'h0BAD});
    do_req("rst2_hi", 32'h40, 3'b000, 32'h0, got);
    check("rst2_hi.const", got, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
